operand_join: RTL

Two-input operand aligner placed directly upstream of the two-operand dataflow operators (OR, AND, ADD, …). Those operators fire only when both operand-ready strobes are high in the same cycle and silently drop a lone operand. This block buffers each operand stream in its own small FIFO and releases one matched pair per cycle, with both strobes asserted together. Its outputs connect 1:1 to the operator's R_IN1/D_IN1/R_IN2/D_IN2.

---
 rtl/operand_join.sv | 83 ++++++++
 1 files changed

// File: rtl/operand_join.sv
// Two-operand aligner: buffers each operand stream in its own FIFO and
// releases one matched pair per cycle with both ready strobes asserted together.
module operand_join #(
    parameter int N     = 16,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          EN,
    input  logic          R_IN1,
    input  logic [N-1:0]  D_IN1,
    input  logic          R_IN2,
    input  logic [N-1:0]  D_IN2,
    output logic          R_OUT1,
    output logic [N-1:0]  D_OUT1,
    output logic          R_OUT2,
    output logic [N-1:0]  D_OUT2,
    output logic [CW-1:0] CNT1,
    output logic [CW-1:0] CNT2,
    output logic          OVF
);

    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem1 [DEPTH];
    logic [N-1:0]  mem2 [DEPTH];
    logic [AW-1:0] wp1, rp1, wp2, rp2;
    logic          r_out;
    logic          pop, push1, push2, drop;

    // A full FIFO still accepts a write when it is popped on the same edge;
    // the slot being written is the head being read, which is sampled pre-edge.
    always_comb begin
        pop   = EN && (CNT1 != '0) && (CNT2 != '0);
        push1 = EN && R_IN1 && ((CNT1 < CW'(DEPTH)) || pop);
        push2 = EN && R_IN2 && ((CNT2 < CW'(DEPTH)) || pop);
        drop  = EN && ((R_IN1 && !push1) || (R_IN2 && !push2));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem1[i] <= '0;
                mem2[i] <= '0;
            end
            wp1    <= '0;
            rp1    <= '0;
            wp2    <= '0;
            rp2    <= '0;
            CNT1   <= '0;
            CNT2   <= '0;
            r_out  <= 1'b0;
            D_OUT1 <= '0;
            D_OUT2 <= '0;
            OVF    <= 1'b0;
        end else if (EN) begin
            r_out <= pop;
            if (pop) begin
                D_OUT1 <= mem1[rp1];
                D_OUT2 <= mem2[rp2];
                rp1    <= rp1 + AW'(1);
                rp2    <= rp2 + AW'(1);
            end
            if (push1) begin
                mem1[wp1] <= D_IN1;
                wp1       <= wp1 + AW'(1);
            end
            if (push2) begin
                mem2[wp2] <= D_IN2;
                wp2       <= wp2 + AW'(1);
            end
            CNT1 <= CNT1 + CW'(push1) - CW'(pop);
            CNT2 <= CNT2 + CW'(push2) - CW'(pop);
            if (drop)
                OVF <= 1'b1;
        end
    end

    assign R_OUT1 = r_out;
    assign R_OUT2 = r_out;

endmodule
